// File: rtl/registers.sv
// picoMIPS register file: %0 reads zero, %1 reads inport, %2 drives outport.
// Optional macro REG_BYPASS_EN adds a combinational write-through path on both read ports.
module registers #(
   parameter int n              = 8,
   parameter int registers_size = 5
) (
   input  logic                      clk,
   input  logic                      n_reset,
   input  logic                      w,
   input  logic [n-1:0]              write_data,
   input  logic [registers_size-1:0] r_dest,
   input  logic [registers_size-1:0] r_source,
   output logic [n-1:0]              rd_data,
   output logic [n-1:0]              rs_data,
   input  logic [n-1:0]              inport,
   output logic [n-1:0]              outport
);

   localparam int NREG = 1 << registers_size;
   localparam logic [registers_size-1:0] ADDR_ZERO = '0;
   localparam logic [registers_size-1:0] ADDR_IN   = registers_size'(1);
   localparam logic [registers_size-1:0] ADDR_OUT  = registers_size'(2);

   logic [n-1:0] regs_q [NREG];
   logic [n-1:0] regs_d [NREG];

   // %0 and %1 are read-only, so writes addressed to them are dropped here.
   always_comb begin
      regs_d = regs_q;
      if (w && (r_dest > ADDR_IN)) begin
         regs_d[r_dest] = write_data;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rd_data = regs_q[r_dest];
      if (r_dest == ADDR_ZERO) begin
         rd_data = '0;
      end else if (r_dest == ADDR_IN) begin
         rd_data = inport;
`ifdef REG_BYPASS_EN
      end else if (w) begin
         rd_data = write_data;
`endif
      end
   end

   always_comb begin
      rs_data = regs_q[r_source];
      if (r_source == ADDR_ZERO) begin
         rs_data = '0;
      end else if (r_source == ADDR_IN) begin
         rs_data = inport;
`ifdef REG_BYPASS_EN
      end else if (w && (r_source == r_dest)) begin
         rs_data = write_data;
`endif
      end
   end

   // outport mirrors stored %2 directly, never the bypass path.
   assign outport = regs_q[ADDR_OUT];

endmodule

// File: tb/tb_registers.sv
// Bench for the picoMIPS register file: directed vector table, corner sequences,
// and randomized traffic against an array-based reference model.
module tb_registers;

   logic       clk;
   logic       n_reset;
   logic       w;
   logic [7:0] write_data;
   logic [4:0] r_dest;
   logic [4:0] r_source;
   logic [7:0] rd_data;
   logic [7:0] rs_data;
   logic [7:0] inport;
   logic [7:0] outport;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mem [32];

   registers #(.n(8), .registers_size(5)) dut (
      .clk(clk), .n_reset(n_reset), .w(w), .write_data(write_data),
      .r_dest(r_dest), .r_source(r_source), .rd_data(rd_data),
      .rs_data(rs_data), .inport(inport), .outport(outport)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       w;
      logic [7:0] wd;
      logic [4:0] rd;
      logic [4:0] rs;
      logic [7:0] inp;
      logic [7:0] exp_rd;
      logic [7:0] exp_rs;
      logic [7:0] exp_out;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] model_read(input logic [4:0] a, input logic bypass_ok);
      if (a == 5'd0) return 8'h00;
      if (a == 5'd1) return inport;
`ifdef REG_BYPASS_EN
      if (bypass_ok && w && a == r_dest) return write_data;
`endif
      return mem[a];
   endfunction

   initial begin
      vecs[0] = '{1'b1, 8'h05, 5'd3, 5'd3, 8'h0B, 8'h05, 8'h05, 8'h00};
      vecs[1] = '{1'b1, 8'h18, 5'd4, 5'd3, 8'h0B, 8'h18, 8'h05, 8'h00};
      vecs[2] = '{1'b0, 8'hAA, 5'd3, 5'd4, 8'h0B, 8'h05, 8'h18, 8'h00};
      vecs[3] = '{1'b1, 8'h0B, 5'd2, 5'd1, 8'h0B, 8'h0B, 8'h0B, 8'h0B};
      vecs[4] = '{1'b1, 8'hFF, 5'd0, 5'd1, 8'h0B, 8'h00, 8'h0B, 8'h0B};
      vecs[5] = '{1'b1, 8'hFF, 5'd1, 5'd0, 8'h0B, 8'h0B, 8'h00, 8'h0B};
      vecs[6] = '{1'b1, 8'h05, 5'd2, 5'd3, 8'hF0, 8'h05, 8'h05, 8'h05};
      vecs[7] = '{1'b0, 8'h77, 5'd2, 5'd4, 8'hF0, 8'h05, 8'h18, 8'h05};
      vecs[8] = '{1'b1, 8'h5A, 5'd2, 5'd1, 8'h3C, 8'h5A, 8'h3C, 8'h5A};
      vecs[9] = '{1'b1, 8'h11, 5'd3, 5'd2, 8'h3C, 8'h11, 8'h5A, 8'h5A};

      n_reset = 1'b0; w = 1'b0; write_data = 8'h00;
      r_dest = 5'd2; r_source = 5'd2; inport = 8'h00;
      #2;
      check("reset_outport", outport, 8'h00);
      check("reset_rd2", rd_data, 8'h00);
      check("reset_rs2", rs_data, 8'h00);
      @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         w = vecs[i].w; write_data = vecs[i].wd;
         r_dest = vecs[i].rd; r_source = vecs[i].rs; inport = vecs[i].inp;
         edge_step();
         check($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
         check($sformatf("vec%0d_rs", i), rs_data, vecs[i].exp_rs);
         check($sformatf("vec%0d_out", i), outport, vecs[i].exp_out);
      end

      // Asynchronous reset mid-cycle, away from any edge.
      w = 1'b0;
      @(negedge clk);
      #2;
      n_reset = 1'b0;
      #1;
      check("async_reset_outport", outport, 8'h00);
      @(negedge clk);
      n_reset = 1'b1;
      r_source = 5'd2; #1;
      check("post_reset_rs2", rs_data, 8'h00);
      r_source = 5'd3; #1;
      check("post_reset_rs3", rs_data, 8'h00);

      // inport tracks combinationally with no clock edge.
      r_source = 5'd1; r_dest = 5'd0; inport = 8'h0B; #1;
      check("inport_rs_0B", rs_data, 8'h0B);
      check("zero_rd", rd_data, 8'h00);
      inport = 8'hF0; #1;
      check("inport_rs_F0", rs_data, 8'hF0);

      // Read-during-write on %6, plus outport holding until the edge.
      w = 1'b1; r_dest = 5'd6; write_data = 8'h21;
      edge_step();
      w = 1'b0; #1;
      w = 1'b1; r_dest = 5'd6; r_source = 5'd6; write_data = 8'h3C; #1;
`ifdef REG_BYPASS_EN
      check("bypass_pre_edge_rs", rs_data, 8'h3C);
      check("bypass_pre_edge_rd", rd_data, 8'h3C);
`else
      check("rdw_pre_edge_rs", rs_data, 8'h21);
      check("rdw_pre_edge_rd", rd_data, 8'h21);
`endif
      edge_step();
      check("rdw_post_edge_rs", rs_data, 8'h3C);
      r_dest = 5'd2; r_source = 5'd7; write_data = 8'h99; #1;
      check("outport_pre_edge", outport, 8'h00);
      edge_step();
      check("outport_post_edge", outport, 8'h99);
      r_dest = 5'd1; r_source = 5'd1; write_data = 8'h44; inport = 8'h6E; #1;
      check("bypass_excl_in", rs_data, 8'h6E);
      r_dest = 5'd0; r_source = 5'd0; #1;
      check("bypass_excl_zero", rs_data, 8'h00);
      edge_step();
      w = 1'b0;

      // Randomized traffic against the array model.
      for (int a = 0; a < 32; a++) mem[a] = 8'h00;
      mem[6] = 8'h3C; mem[2] = 8'h99;
      for (int k = 0; k < 400; k++) begin
         w = ($urandom_range(0, 3) != 0);
         write_data = 8'($urandom);
         r_dest = 5'($urandom);
         r_source = ($urandom_range(0, 4) == 0) ? r_dest : 5'($urandom);
         inport = 8'($urandom);
         #1;
         check("rand_rd", rd_data, model_read(r_dest, 1'b1));
         check("rand_rs", rs_data, model_read(r_source, 1'b1));
         check("rand_out", outport, mem[2]);
         if (w && r_dest > 5'd1) mem[r_dest] = write_data;
         edge_step();
         check("rand_out_post", outport, mem[2]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/registers.md
Name: registers

Overview:
- General-purpose register file for the picoMIPS datapath.
- 2^registers_size registers, each n bits wide.
- Two combinational read ports (rd, rs) and one synchronous write port.
- Special registers:
  - %0 always reads zero.
  - %1 reads the external inport.
  - %2 drives the external outport.

Parameters:
- n, 8, data width of every register, write_data, read ports, inport and outport.
- registers_size, 5, register-address width; the file holds 2^registers_size entries.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_reset  input  1  asynchronous active-low reset.
- w  input  1  write enable; write occurs on a rising clk edge while w=1.
- write_data  input  n  data written to register r_dest.
- r_dest  input  registers_size  destination register number: write address and rd read address.
- r_source  input  registers_size  source register number (rs read address).
- rd_data  output  n  combinational contents of register r_dest.
- rs_data  output  n  combinational contents of register r_source.
- inport  input  n  external input, visible as register %1.
- outport  output  n  external output, always equal to stored register %2.

Behaviour:
- Storage: array of 2^registers_size n-bit registers. Physical storage for %0 and %1 is optional; both are read-only.
- Reset: n_reset=0 asynchronously clears every stored register to 0, so outport=0 immediately. Reset dominates w. Release is synchronous-safe: first write takes effect on the first rising edge with n_reset=1.
- Write:
  - On rising clk with n_reset=1 and w=1, reg[r_dest] <= write_data.
  - Writes to %0 or %1 are silently discarded.
  - w=0 leaves all registers unchanged.
- Read (combinational, zero latency):
  - Address 0 returns all zeros.
  - Address 1 returns the current inport value, tracking inport changes with no clock.
  - Any other address returns the stored register.
- rd_data and rs_data are independent; both may address the same register.
- Read-during-write (base build): reads return the old value until the clock edge, and the new value after it.
- outport:
  - Continuously equals stored %2; no extra register stage.
  - Updates in the same edge a write to %2 occurs.
  - Stable otherwise.
- Address width: all 2^registers_size addresses are valid; there is no out-of-range case.
- Widths: write_data is stored unmodified (no sign or zero extension).

Optional Feature:
- Macro: REG_BYPASS_EN.
- Defined: write-through bypass. While w=1 and a read address equals r_dest, that read port returns write_data combinationally, before the edge. Exceptions: addresses 0 and 1 keep returning 0 and inport respectively. outport is not bypassed; it still changes only on the clock edge.
- Undefined: no bypass; read-during-write returns the old value as in Behaviour.

Test Plan:
- Reset: assert n_reset=0 mid-cycle after writing %2=0x5A and %3=0x11 -> outport=0 immediately; after release, rs_data=0 for r_source=2 and 3.
- Special reads:
  - inport=0x0B, r_source=1 -> rs_data=0x0B with no clock edge.
  - r_dest=0 -> rd_data=0x00.
  - Change inport to 0xF0 -> rs_data follows combinationally.
- Copy to outport: with rs_data=0x0B from %1, set r_dest=2, write_data=rs_data, w=1, one rising edge -> outport=0x0B, rd_data=0x0B.
- Plain writes:
  - write 5 to %3, 24 to %4 on successive edges with w=1 -> reading r_source=3 gives 5 and 4 gives 24.
  - w=0 edges leave the values unchanged.
  - Copy %3 to %2 -> outport=0x05.
- Protected registers: w=1, write_data=0xFF, r_dest=0 then r_dest=1 -> reads of 0 stay 0x00, reads of 1 still equal inport; outport unchanged.
- Bypass (REG_BYPASS_EN only): w=1, r_dest=r_source=6, write_data=0x3C before the edge -> rs_data=0x3C pre-edge. Without the macro, rs_data shows the old value until the edge.
